ram_stream_reader: RTL

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_pkg.sv | 29 ++
 rtl/stream_fifo2.sv | 72 +++++++
 rtl/ram_stream_reader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the RAM stream reader.
//   RAM_DEPTH_DEFAULT / RAM_WIDTH_DEFAULT : default source RAM geometry
//   reader_state_t                        : reader control states
//   fifo_occupancy()                      : entry count from full/empty flags
package ram_pkg;

    localparam int RAM_DEPTH_DEFAULT = 256;
    localparam int RAM_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } reader_state_t;

    // A 2-entry buffer holds 0, 1 or 2 words; derive the count from its flags.
    function automatic logic [2:0] fifo_occupancy(input logic full, input logic empty);
        logic [2:0] occ;
        if (full) begin
            occ = 3'd2;
        end else if (empty) begin
            occ = 3'd0;
        end else begin
            occ = 3'd1;
        end
        return occ;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: two-entry first-word-fall-through buffer with a registered head.
//   clk, reset           : clock, synchronous active-high reset
//   push, push_data      : write one word
//   pop                  : remove the head word (ignored when empty)
//   full, empty          : occupancy flags
//   head                 : oldest stored word, held stable until popped
module stream_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = pop && (r_count != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_push_ok = push && ((r_count != 2'd2) || w_pop_ok);

    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign head  = r_head;

    // Storage update: head always holds the oldest word, tail the younger one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= push_data;
                    end else begin
                        r_tail <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous write and pop: occupancy unchanged, queue shifts.
                    if (r_count == 2'd1) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of consecutive (wrapping) words from a
// synchronous-read RAM and presents them on a valid/ready stream.
//   clk, reset            : clock, synchronous active-high reset
//   start, base_addr,
//   length                : burst request (sampled only when idle)
//   rd_address, read_data : RAM read port (data returns one cycle after address)
//   m_data, m_valid,
//   m_ready               : output stream
//   busy, done            : burst in progress / final word transferred
//   m_last                : final-word marker, present only with STREAM_LAST_EN
// Optional feature macro: STREAM_LAST_EN
//
// A read is "issued" in the cycle its address sits on rd_address; the data is
// pushed into the output buffer at the end of the following cycle.
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter  int MEM_DEPTH = RAM_DEPTH_DEFAULT,
    parameter  int MEM_WIDTH = RAM_WIDTH_DEFAULT,
    localparam int AW        = $clog2(MEM_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [LW-1:0]        length,
    output logic [AW-1:0]        rd_address,
    input  logic [MEM_WIDTH-1:0] read_data,
    output logic [MEM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
`ifdef STREAM_LAST_EN
    ,
    output logic                 m_last
`endif
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_DEPTH - 1);

    reader_state_t        r_state;
    logic [AW-1:0]        r_addr;
    logic [LW-1:0]        r_len;
    logic [LW-1:0]        r_issue_cnt;
    logic [LW-1:0]        r_out_cnt;
    logic                 r_inflight;
    logic                 r_busy;
    logic                 r_done_zero;

    logic                 w_full;
    logic                 w_empty;
    logic [MEM_WIDTH-1:0] w_head;
    logic                 w_pop;
    logic [2:0]           w_pending;
    logic                 w_issue;
    logic                 w_last_xfer;

    stream_fifo2 #(
        .WIDTH (MEM_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (read_data),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign m_valid    = !w_empty;
    assign m_data     = w_head;
    assign rd_address = r_addr;
    assign busy       = r_busy;
    assign w_pop      = m_valid && m_ready;
    assign done       = r_done_zero || w_last_xfer;

`ifdef STREAM_LAST_EN
    assign m_last = m_valid && (r_out_cnt == (r_len - LW'(1)));
`endif

    // Issue gating: buffered words plus the read in flight, less this cycle's
    // pop, must leave room so that returning data is never dropped.
    always_comb begin
        w_pending   = fifo_occupancy(w_full, w_empty) + {2'b00, r_inflight};
        w_issue     = 1'b0;
        w_last_xfer = 1'b0;
        if ((r_state == ST_STREAM) && (r_issue_cnt != r_len)) begin
            if (w_pending < (3'd2 + {2'b00, w_pop})) begin
                w_issue = 1'b1;
            end else begin
                w_issue = 1'b0;
            end
        end else begin
            w_issue = 1'b0;
        end
        if ((r_state == ST_DRAIN) && w_pop && (r_out_cnt == (r_len - LW'(1)))) begin
            w_last_xfer = 1'b1;
        end else begin
            w_last_xfer = 1'b0;
        end
    end

    // Control FSM, address generator and burst counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done_zero <= 1'b0;
        end else begin
            r_done_zero <= 1'b0;
            r_inflight  <= w_issue;
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + LW'(1);
            end
            if (w_issue) begin
                r_addr      <= (r_addr == ADDR_LAST) ? '0 : (r_addr + AW'(1));
                r_issue_cnt <= r_issue_cnt + LW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            // Empty burst: acknowledge without touching the RAM.
                            r_done_zero <= 1'b1;
                        end else begin
                            r_state     <= ST_STREAM;
                            r_busy      <= 1'b1;
                            r_len       <= length;
                            r_addr      <= base_addr;
                            r_issue_cnt <= '0;
                            r_out_cnt   <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_issue && ((r_issue_cnt + LW'(1)) == r_len)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_xfer) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
